// File: rtl/if_buffer_if.sv
// Fetch-to-decode handshake bundle for the instruction-fetch buffer.
// slave is the buffer side; master is the fetch/decode/redirect side.
interface if_buffer_if #(
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic          in_valid;
    logic [31:0]   in_pc;
    logic [31:0]   in_instr;
    logic          in_ready;
    logic          out_valid;
    logic          out_ready;
    logic [31:0]   out_pc;
    logic [31:0]   out_instr;
    logic          out_first;
    logic          flush;
    logic [CW-1:0] count;

    modport slave (
        input  in_valid, in_pc, in_instr, out_ready, flush,
        output in_ready, out_valid, out_pc, out_instr, out_first, count
    );

    modport master (
        output in_valid, in_pc, in_instr, out_ready, flush,
        input  in_ready, out_valid, out_pc, out_instr, out_first, count
    );
endinterface

// File: rtl/if_buffer.sv
// Instruction fetch buffer: DEPTH-entry FIFO between fetch and decode, with
// flush on redirect and a tag marking the first entry after reset/flush.
module if_buffer #(
    parameter int DEPTH = 4
) (
    input  logic          clk,
    input  logic          clr,
    if_buffer_if.slave    bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [PW-1:0] PTR_ONE = PW'(1);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    typedef struct packed {
        logic        first;
        logic [31:0] pc;
        logic [31:0] instr;
    } entry_t;

    entry_t        mem_q [DEPTH];
    entry_t        mem_d [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          first_pend_q, first_pend_d;

    logic   push, pop, out_valid;
    entry_t head;

    // Outputs depend only on state, so there is no in_* -> out_* path.
    assign out_valid    = (count_q != '0);
    assign head         = mem_q[rd_ptr_q];
    assign bus.in_ready = (count_q < DEPTH_C) && !bus.flush && !clr;
    assign bus.out_valid = out_valid;
    assign bus.out_pc    = out_valid ? head.pc    : 32'h0;
    assign bus.out_instr = out_valid ? head.instr : 32'h0;
    assign bus.out_first = out_valid ? head.first : 1'b0;
    assign bus.count     = count_q;

    assign push = bus.in_valid && bus.in_ready;
    assign pop  = out_valid && bus.out_ready;

    always_comb begin
        mem_d        = mem_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;
        first_pend_d = first_pend_q;
        if (clr || bus.flush) begin
            // Storage is left alone; count 0 keeps stale slots off the outputs.
            wr_ptr_d     = '0;
            rd_ptr_d     = '0;
            count_d      = '0;
            first_pend_d = 1'b1;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = '{first: first_pend_q, pc: bus.in_pc, instr: bus.in_instr};
                wr_ptr_d        = wr_ptr_q + PTR_ONE;
                first_pend_d    = 1'b0;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_ONE;
            end
            if (push && !pop) begin
                count_d = count_q + CNT_ONE;
            end else if (pop && !push) begin
                count_d = count_q - CNT_ONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            first_pend_q <= 1'b1;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            first_pend_q <= first_pend_d;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end
endmodule

// File: tb/tb_if_buffer.sv
// Directed bench for if_buffer (DEPTH=4): ordering, first tag, full/empty,
// wrap-around, flush and clr priority, with hand-computed expectations.
module tb_if_buffer;
    logic clk = 1'b0;
    logic clr = 1'b1;
    int   nvec = 0;
    int   nerr = 0;

    always #5 clk = ~clk;

    if_buffer_if #(.DEPTH(4)) bus ();
    if_buffer #(.DEPTH(4)) dut (.clk(clk), .clr(clr), .bus(bus));

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [31:0] pc, input logic rdy);
        bus.in_valid  = v;
        bus.in_pc     = pc;
        bus.in_instr  = pc ^ 32'hA5A5_0000;
        bus.out_ready = rdy;
        #1;
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_pc     = '0;
        bus.in_instr  = '0;
        bus.out_ready = 1'b0;
        bus.flush     = 1'b0;

        // reset state
        step();
        chk("rst_count", 32'(bus.count), 32'd0);
        chk("rst_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_inrdy_clr", 32'(bus.in_ready), 32'd0);
        chk("rst_pc", bus.out_pc, 32'h0);
        clr = 1'b0;
        #1;
        chk("rst_inrdy", 32'(bus.in_ready), 32'd1);

        // three pushes, decode stalled; first entry visible after one edge
        drive(1'b1, 32'h3000, 1'b0);
        step();
        chk("lat_valid", 32'(bus.out_valid), 32'd1);
        chk("lat_pc", bus.out_pc, 32'h3000);
        drive(1'b1, 32'h3004, 1'b0); step();
        drive(1'b1, 32'h3008, 1'b0); step();
        chk("fill3_count", 32'(bus.count), 32'd3);
        chk("fill3_pc", bus.out_pc, 32'h3000);
        chk("fill3_first", 32'(bus.out_first), 32'd1);

        // drain in order, first tag 1,0,0
        drive(1'b0, 32'h0, 1'b1);
        chk("drain0_pc", bus.out_pc, 32'h3000);
        chk("drain0_first", 32'(bus.out_first), 32'd1);
        step();
        chk("drain1_pc", bus.out_pc, 32'h3004);
        chk("drain1_first", 32'(bus.out_first), 32'd0);
        step();
        chk("drain2_pc", bus.out_pc, 32'h3008);
        chk("drain2_instr", bus.out_instr, 32'hA5A5_3008);
        chk("drain2_first", 32'(bus.out_first), 32'd0);
        step();
        chk("empty_valid", 32'(bus.out_valid), 32'd0);
        chk("empty_pc", bus.out_pc, 32'h0);
        chk("empty_instr", bus.out_instr, 32'h0);
        chk("empty_first", 32'(bus.out_first), 32'd0);

        // fill to full, offer a 5th
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 32'h4000 + 32'(4 * i), 1'b0);
            step();
        end
        chk("full_count", 32'(bus.count), 32'd4);
        chk("full_inrdy", 32'(bus.in_ready), 32'd0);
        drive(1'b1, 32'h4010, 1'b0);
        step();
        chk("full_reject_count", 32'(bus.count), 32'd4);
        chk("full_head_pc", bus.out_pc, 32'h4000);
        // pop while full: slot frees only from the next cycle
        drive(1'b0, 32'h0, 1'b1);
        chk("full_pop_inrdy", 32'(bus.in_ready), 32'd0);
        step();
        chk("after_pop_count", 32'(bus.count), 32'd3);
        chk("after_pop_inrdy", 32'(bus.in_ready), 32'd1);
        // six push/pop pairs: heads 0x4004..0x4018, pushes 0x4010..0x4024
        for (int k = 0; k < 6; k++) begin
            drive(1'b1, 32'h4010 + 32'(4 * k), 1'b1);
            chk("wrap_head_pc", bus.out_pc, 32'h4004 + 32'(4 * k));
            step();
            chk("wrap_count", 32'(bus.count), 32'd3);
        end
        chk("wrap_first", 32'(bus.out_first), 32'd0);
        drive(1'b0, 32'h0, 1'b1);
        for (int k = 0; k < 3; k++) begin
            chk("wrap_drain_pc", bus.out_pc, 32'h401C + 32'(4 * k));
            step();
        end
        chk("wrap_empty", 32'(bus.out_valid), 32'd0);

        // flush with count=2 and a push offered
        drive(1'b1, 32'h5000, 1'b0); step();
        drive(1'b1, 32'h5004, 1'b0); step();
        chk("preflush_count", 32'(bus.count), 32'd2);
        bus.flush = 1'b1;
        drive(1'b1, 32'h3100, 1'b0);
        chk("flush_inrdy", 32'(bus.in_ready), 32'd0);
        step();
        chk("flush_count", 32'(bus.count), 32'd0);
        chk("flush_valid", 32'(bus.out_valid), 32'd0);
        chk("flush_pc", bus.out_pc, 32'h0);
        bus.flush = 1'b0;
        drive(1'b1, 32'h3200, 1'b0);
        step();
        chk("postflush_pc", bus.out_pc, 32'h3200);
        chk("postflush_first", 32'(bus.out_first), 32'd1);
        drive(1'b0, 32'h0, 1'b1);
        step();
        chk("postflush_empty", 32'(bus.count), 32'd0);

        // concurrent push+pop at count=1 for 10 cycles
        drive(1'b1, 32'h6000, 1'b0);
        step();
        for (int k = 0; k < 10; k++) begin
            drive(1'b1, 32'h6004 + 32'(4 * k), 1'b1);
            chk("pp_head_pc", bus.out_pc, 32'h6000 + 32'(4 * k));
            step();
            chk("pp_count", 32'(bus.count), 32'd1);
        end
        chk("pp_last_pc", bus.out_pc, 32'h6028);
        chk("pp_last_first", 32'(bus.out_first), 32'd0);
        drive(1'b0, 32'h0, 1'b1);
        step();

        // clr + flush together mid-stream, push and pop pending
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'h7000 + 32'(4 * i), 1'b0);
            step();
        end
        chk("preclr_count", 32'(bus.count), 32'd3);
        clr       = 1'b1;
        bus.flush = 1'b1;
        drive(1'b1, 32'h7010, 1'b1);
        step();
        chk("clr_count", 32'(bus.count), 32'd0);
        chk("clr_valid", 32'(bus.out_valid), 32'd0);
        chk("clr_pc", bus.out_pc, 32'h0);
        clr       = 1'b0;
        bus.flush = 1'b0;
        drive(1'b1, 32'h7100, 1'b0);
        step();
        chk("postclr_count", 32'(bus.count), 32'd1);
        chk("postclr_pc", bus.out_pc, 32'h7100);
        chk("postclr_first", 32'(bus.out_first), 32'd1);
        drive(1'b0, 32'h0, 1'b0);
        step();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
